// File: rtl/proc_pkg.sv
// Shared definitions for the 16-instruction processor: opcodes, sequencer
// state encoding, default widths and instruction field positions.
package proc_pkg;

    localparam int PC_W_DEF    = 4;
    localparam int INSTR_W_DEF = 16;
    localparam int IMM_W_DEF   = 8;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_LOAD = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_SUBI = 4'b1011;
    localparam logic [3:0] OP_BR   = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1110;
    localparam logic [3:0] OP_OUT  = 4'b1111;

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_EXEC  = 3'd1;
    localparam logic [2:0] S_WB    = 3'd2;
    localparam logic [2:0] S_OUT   = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;
    localparam logic [2:0] S_STEP  = 3'd5;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS_HI  = 8;
    localparam int RS_LO  = 6;
    localparam int TGT_HI = 11;
    localparam int TGT_LO = 8;

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of the latched instruction into register selects,
// immediate and opcode class flags for the sequencer.
module instr_decoder
    import proc_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int IMM_W   = IMM_W_DEF
) (
    input  logic [INSTR_W-1:0] ir,
    output logic [3:0]         op,
    output logic [2:0]         rd_sel,
    output logic [2:0]         rs_sel,
    output logic [IMM_W-1:0]   imm,
    output logic               use_imm,
    output logic               is_alu,
    output logic               is_flag,
    output logic               is_jmp,
    output logic               is_br,
    output logic               is_out,
    output logic               illegal
);

    assign op     = ir[OP_HI:OP_LO];
    assign rd_sel = ir[RD_HI:RD_LO];
    assign rs_sel = ir[RS_HI:RS_LO];
    assign imm    = ir[IMM_W-1:0];

    always_comb begin
        use_imm = 1'b0;
        is_alu  = 1'b0;
        is_flag = 1'b0;
        is_jmp  = 1'b0;
        is_br   = 1'b0;
        is_out  = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_NOP:  ;
            OP_LOAD: begin is_alu = 1'b1; use_imm = 1'b1; end
            OP_ADD:  begin is_alu = 1'b1; is_flag = 1'b1; end
            OP_SUB:  begin is_alu = 1'b1; is_flag = 1'b1; end
            OP_SUBI: begin is_alu = 1'b1; is_flag = 1'b1; use_imm = 1'b1; end
            OP_MOV:  is_alu = 1'b1;
            OP_JMP:  is_jmp = 1'b1;
            OP_BR:   is_br  = 1'b1;
            OP_OUT:  is_out = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute/writeback control unit owning the PC and IR.
// Optional FETCH_SEQ_SINGLE_STEP_EN adds a step input gating each retire.
module fetch_sequencer
    import proc_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int IMM_W   = IMM_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic               run,
    output logic [PC_W-1:0]    rom_address,
    input  logic [INSTR_W-1:0] rom_instruction,
    input  logic               zero_flag,
    output logic [3:0]         op,
    output logic [2:0]         rd_sel,
    output logic [2:0]         rs_sel,
    output logic [IMM_W-1:0]   imm,
    output logic               use_imm,
    output logic               alu_en,
    output logic               reg_we,
    output logic               flag_we,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    pc,
    output logic               retired,
    output logic               halted
);

`ifdef FETCH_SEQ_SINGLE_STEP_EN
    localparam logic [2:0] S_RETIRE = S_STEP;
`else
    localparam logic [2:0] S_RETIRE = S_FETCH;
`endif

    logic [2:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               is_alu, is_flag, is_jmp, is_br, is_out, illegal;
    logic [PC_W-1:0]    target;

    instr_decoder #(.INSTR_W(INSTR_W), .IMM_W(IMM_W)) u_dec (
        .ir      (ir_q),
        .op      (op),
        .rd_sel  (rd_sel),
        .rs_sel  (rs_sel),
        .imm     (imm),
        .use_imm (use_imm),
        .is_alu  (is_alu),
        .is_flag (is_flag),
        .is_jmp  (is_jmp),
        .is_br   (is_br),
        .is_out  (is_out),
        .illegal (illegal)
    );

    assign target      = PC_W'(ir_q[TGT_HI:TGT_LO]);
    assign rom_address = pc_q;
    assign pc          = pc_q;
    assign out_valid   = (state_q == S_OUT);
    assign halted      = (state_q == S_HALT);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        alu_en  = 1'b0;
        reg_we  = 1'b0;
        flag_we = 1'b0;
        retired = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (run) begin
                    ir_d    = rom_instruction;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (illegal) begin
                    state_d = S_HALT;
                end else if (is_alu) begin
                    alu_en  = 1'b1;
                    state_d = S_WB;
                end else if (is_out) begin
                    state_d = S_OUT;
                end else begin
                    // NOP, JMP and BR all retire straight from execute
                    retired = 1'b1;
                    state_d = S_RETIRE;
                    if (is_jmp || (is_br && zero_flag))
                        pc_d = target;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                flag_we = is_flag;
                retired = 1'b1;
                state_d = S_RETIRE;
            end
            S_OUT: begin
                if (out_ready) begin
                    retired = 1'b1;
                    state_d = S_RETIRE;
                end
            end
            S_HALT: ;
`ifdef FETCH_SEQ_SINGLE_STEP_EN
            S_STEP: begin
                if (step)
                    state_d = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer (default build): an instruction-level model
// compared every cycle, plus hand-computed literal expectations.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, out_ready, zero_flag;
    logic [3:0]  rom_address, pc, op;
    logic [15:0] rom_instruction;
    logic [2:0]  rd_sel, rs_sel;
    logic [7:0]  imm;
    logic        use_imm, alu_en, reg_we, flag_we, out_valid, retired, halted;

    logic [15:0] rom [16];
    assign rom_instruction = rom[rom_address];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .run             (run),
        .rom_address     (rom_address),
        .rom_instruction (rom_instruction),
        .zero_flag       (zero_flag),
        .op              (op),
        .rd_sel          (rd_sel),
        .rs_sel          (rs_sel),
        .imm             (imm),
        .use_imm         (use_imm),
        .alu_en          (alu_en),
        .reg_we          (reg_we),
        .flag_we         (flag_we),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .pc              (pc),
        .retired         (retired),
        .halted          (halted)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: age counts cycles since the fetch of the
    // current instruction (0 = waiting to fetch).
    int          m_age = 0;
    logic [3:0]  m_pc = '0;
    logic [15:0] m_ir = '0;
    bit          m_halt = 1'b0;
    bit          chk_en = 1'b0;

    function automatic bit f_alu(input logic [3:0] o);
        return o inside {4'h1, 4'h2, 4'h3, 4'hB, 4'hE};
    endfunction
    function automatic bit f_flag(input logic [3:0] o);
        return o inside {4'h2, 4'h3, 4'hB};
    endfunction
    function automatic bit f_legal(input logic [3:0] o);
        return o inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'hB, 4'hC, 4'hE, 4'hF};
    endfunction

    function automatic bit exp_retired();
        logic [3:0] o;
        o = m_ir[15:12];
        if (m_halt) return 1'b0;
        return (m_age == 1 && o inside {4'h0, 4'h8, 4'hC}) ||
               (m_age == 2 && f_alu(o)) ||
               (m_age >= 2 && o == 4'hF && out_ready);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pc = '0; m_ir = '0; m_age = 0; m_halt = 1'b0; chk_en = 1'b1;
        end else if (!m_halt) begin
            if (m_age == 0) begin
                if (run) begin
                    m_ir = rom[m_pc];
                    m_pc = m_pc + 4'd1;
                    m_age = 1;
                end
            end else if (m_age == 1 && !f_legal(m_ir[15:12])) begin
                m_halt = 1'b1;
                m_age = 0;
            end else if (exp_retired()) begin
                if (m_ir[15:12] == 4'h8 || (m_ir[15:12] == 4'hC && zero_flag))
                    m_pc = m_ir[11:8];
                m_age = 0;
            end else begin
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", pc, m_pc);
            chk("rom_address", rom_address, m_pc);
            chk("op", op, m_ir[15:12]);
            chk("rd_sel", rd_sel, m_ir[11:9]);
            chk("rs_sel", rs_sel, m_ir[8:6]);
            chk("imm", imm, m_ir[7:0]);
            chk("use_imm", use_imm, m_ir[15:12] inside {4'h1, 4'hB});
            chk("alu_en", alu_en, !m_halt && m_age == 1 && f_alu(m_ir[15:12]));
            chk("reg_we", reg_we, m_age == 2 && f_alu(m_ir[15:12]));
            chk("flag_we", flag_we, m_age == 2 && f_flag(m_ir[15:12]));
            chk("out_valid", out_valid, m_age >= 2 && m_ir[15:12] == 4'hF);
            chk("retired", retired, exp_retired());
            chk("halted", halted, m_halt);
        end
    end

    initial begin
        rst = 1'b1; run = 1'b0; out_ready = 1'b0; zero_flag = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
        rom[0]  = 16'h1E07;
        rom[1]  = 16'hFE00;
        rom[2]  = 16'hCA00;
        rom[10] = 16'h2A40;
        rom[11] = 16'hCA00;
        rom[12] = 16'hB205;
        rom[13] = 16'hE280;
        rom[14] = 16'h8700;
        rom[7]  = 16'h8F00;
        rom[15] = 16'h0000;
        @(posedge clk);

        // Program walk: load, stalled out, branches, jumps, wrap, run drop
        for (int k = 0; k < 34; k++) begin
            #1;
            rst = 1'b0;
            run = (k < 28);
            out_ready = (k == 9);
            zero_flag = (k < 12);
            @(negedge clk);
            case (k)
                1: chk("A_alu_en_c1", alu_en, 1);
                2: begin
                    chk("A_reg_we_c2", reg_we, 1);
                    chk("A_retired_c2", retired, 1);
                    chk("A_rd_sel_c2", rd_sel, 7);
                    chk("A_imm_c2", imm, 7);
                    chk("A_use_imm_c2", use_imm, 1);
                    chk("A_pc_c2", pc, 1);
                end
                4: chk("A_pc_out_exec", pc, 2);
                5, 6, 7, 8: begin
                    chk("A_out_valid_stall", out_valid, 1);
                    chk("A_rd_sel_stall", rd_sel, 7);
                    chk("A_retired_stall", retired, 0);
                end
                9: begin
                    chk("A_out_valid_ready", out_valid, 1);
                    chk("A_retired_ready", retired, 1);
                end
                10: begin
                    chk("A_out_valid_drop", out_valid, 0);
                    chk("A_pc_after_out", pc, 2);
                end
                11: chk("A_br_taken_retire", retired, 1);
                12: chk("A_br_taken_pc", pc, 10);
                14: chk("A_add_flag_we", flag_we, 1);
                17: chk("A_br_not_taken_pc", pc, 12);
                22: chk("A_mov_no_flag", flag_we, 0);
                25: chk("A_jmp_target", rom_address, 7);
                27: chk("A_jmp_target2", rom_address, 15);
                29: chk("A_nop_wrap", pc, 0);
                33: chk("A_run_hold", pc, 0);
                default: ;
            endcase
            @(posedge clk);
        end

        // Illegal opcode halts; reset clears it
        #1;
        rst = 1'b1;
        run = 1'b0;
        rom[0] = 16'h4000;
        @(posedge clk);
        for (int k = 0; k < 9; k++) begin
            #1;
            rst = (k == 7);
            run = 1'b1;
            out_ready = 1'b0;
            zero_flag = 1'b0;
            @(negedge clk);
            if (k == 1) begin
                chk("B_no_alu_en", alu_en, 0);
                chk("B_no_retire", retired, 0);
            end
            if (k >= 2 && k <= 7) begin
                chk("B_halted", halted, 1);
                chk("B_pc_frozen", pc, 1);
            end
            if (k == 8) begin
                chk("B_halt_cleared", halted, 0);
                chk("B_pc_reset", pc, 0);
            end
            @(posedge clk);
        end

        // Reset during a stalled OUT aborts without retire
        #1;
        rst = 1'b1;
        rom[0] = 16'hFE00;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            #1;
            rst = (k == 3);
            run = 1'b1;
            out_ready = 1'b0;
            @(negedge clk);
            if (k == 3) chk("C_out_valid_before_rst", out_valid, 1);
            if (k == 4) begin
                chk("C_out_valid_after_rst", out_valid, 0);
                chk("C_no_retire", retired, 0);
                chk("C_pc_reset", pc, 0);
            end
            if (k == 5) chk("C_fetch_resumed", rom_address, 1);
            @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
